// File: rtl/tune_player.sv
`default_nettype none
// ============================================================================
// Module      : tune_player
// Description : Plays one of up to four ROM tunes on a differential piezo.
//               A one-cycle go pulse latches tune_sel and starts playback;
//               stop aborts without a done pulse. Optional silent gap after
//               every note. Optional repeat mode (macro TUNE_REPEAT_EN).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CLK_FREQ_HZ : clk frequency; note half-period = CLK_FREQ_HZ/(2*f_note)
//   FAST_SIM    : 1 -> duration unit 2^10 cycles, 0 -> 2^22 cycles
//   NUM_TUNES   : tunes enabled (1..4); go with tune_sel >= NUM_TUNES ignored
//   GAP_CYCLES  : silent cycles after each note (0 = no gap)
// Ports
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   go          in   one-cycle start pulse
//   stop        in   abort request (level)
//   tune_sel    in   [1:0] tune index, latched on accepted go
//   tune_repeat in   restart tune at its end (only with TUNE_REPEAT_EN;
//                    "repeat" itself is a reserved word)
//   piezo       out  piezo drive +
//   piezo_n     out  piezo drive -
//   busy        out  high while a tune is playing
//   done        out  one-cycle pulse on natural completion
//   note_idx    out  [2:0] index of the note currently playing
// Configuration macro: TUNE_REPEAT_EN
// ============================================================================
module tune_player #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int FAST_SIM    = 0,
    parameter int NUM_TUNES   = 4,
    parameter int GAP_CYCLES  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       stop,
    input  logic [1:0] tune_sel,
`ifdef TUNE_REPEAT_EN
    input  logic       tune_repeat,
`endif
    output logic       piezo,
    output logic       piezo_n,
    output logic       busy,
    output logic       done,
    output logic [2:0] note_idx
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    function automatic int f_half_period(input int hz);
        int hp;
        hp = CLK_FREQ_HZ / (2 * hz);
        return (hp < 1) ? 1 : hp;
    endfunction

    localparam int c_UNIT_LOG2 = (FAST_SIM != 0) ? 10 : 22;
    localparam int c_DUR_MAX   = 8 << c_UNIT_LOG2;          // longest note
    localparam int c_CNT_MAX   = (GAP_CYCLES > c_DUR_MAX) ? GAP_CYCLES : c_DUR_MAX;
    localparam int c_CNT_W     = $clog2(c_CNT_MAX + 1);

    localparam int c_HP_G6     = f_half_period(1568);
    localparam int c_HP_C7     = f_half_period(2093);
    localparam int c_HP_E7     = f_half_period(2637);
    localparam int c_HP_G7     = f_half_period(3136);
    localparam int c_TONE_W    = $clog2(c_HP_G6 + 1);       // G6 is the longest half-period

    localparam logic [c_CNT_W-1:0] c_GAP_LAST =
        c_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    localparam logic [2:0] c_N_REST = 3'd0;
    localparam logic [2:0] c_N_G6   = 3'd1;
    localparam logic [2:0] c_N_C7   = 3'd2;
    localparam logic [2:0] c_N_E7   = 3'd3;
    localparam logic [2:0] c_N_G7   = 3'd4;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_PLAY   = 2'd1;
    localparam logic [1:0] c_ST_GAP    = 2'd2;
    localparam logic [1:0] c_ST_FINISH = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = c_ST_IDLE,
        ST_PLAY   = c_ST_PLAY,
        ST_GAP    = c_ST_GAP,
        ST_FINISH = c_ST_FINISH
    } state_t;

    // ------------------------------------------------------------------
    // Tune ROM: {note[2:0], units[3:0]}
    // ------------------------------------------------------------------
    function automatic logic [6:0] f_rom(input logic [1:0] tune, input logic [2:0] idx);
        logic [6:0] v;
        v = {c_N_REST, 4'd1};
        case ({tune, idx})
            5'b00_000: v = {c_N_G6,   4'd2};
            5'b00_001: v = {c_N_C7,   4'd2};
            5'b00_010: v = {c_N_E7,   4'd2};
            5'b00_011: v = {c_N_G7,   4'd3};
            5'b00_100: v = {c_N_E7,   4'd1};
            5'b00_101: v = {c_N_G7,   4'd4};
            5'b01_000: v = {c_N_C7,   4'd1};
            5'b01_001: v = {c_N_REST, 4'd1};
            5'b01_010: v = {c_N_C7,   4'd1};
            5'b01_011: v = {c_N_REST, 4'd1};
            5'b01_100: v = {c_N_G7,   4'd2};
            5'b10_000: v = {c_N_E7,   4'd1};
            5'b10_001: v = {c_N_G6,   4'd1};
            5'b10_010: v = {c_N_E7,   4'd1};
            5'b10_011: v = {c_N_G6,   4'd1};
            5'b11_000: v = {c_N_G7,   4'd8};
            default:   v = {c_N_REST, 4'd1};
        endcase
        return v;
    endfunction

    function automatic logic [2:0] f_note(input logic [1:0] tune, input logic [2:0] idx);
        logic [6:0] v;
        v = f_rom(tune, idx);
        return v[6:4];
    endfunction

    // Index of the final note of each tune
    function automatic logic [2:0] f_last(input logic [1:0] tune);
        logic [2:0] v;
        case (tune)
            2'd0:    v = 3'd5;
            2'd1:    v = 3'd4;
            2'd2:    v = 3'd3;
            default: v = 3'd0;
        endcase
        return v;
    endfunction

    // Terminal count of the tone counter (half-period - 1)
    function automatic logic [c_TONE_W-1:0] f_tone_last(input logic [2:0] note);
        logic [c_TONE_W-1:0] v;
        case (note)
            c_N_G6:  v = c_TONE_W'(c_HP_G6 - 1);
            c_N_C7:  v = c_TONE_W'(c_HP_C7 - 1);
            c_N_E7:  v = c_TONE_W'(c_HP_E7 - 1);
            c_N_G7:  v = c_TONE_W'(c_HP_G7 - 1);
            default: v = '0;
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              r_state_q,   w_state_d;
    logic [1:0]          r_tune_q,    w_tune_d;
    logic [2:0]          r_idx_q,     w_idx_d;
    logic [c_CNT_W-1:0]  r_cnt_q,     w_cnt_d;      // note duration / gap counter
    logic [c_TONE_W-1:0] r_tone_q,    w_tone_d;     // half-period counter
    logic                r_piezo_q,   w_piezo_d;
    logic                r_piezo_n_q, w_piezo_n_d;
    logic                r_busy_q,    w_busy_d;
    logic                r_done_q,    w_done_d;

    logic [6:0]          w_cur;
    logic                w_cur_rest;
    logic [c_CNT_W-1:0]  w_note_last;
    logic [c_TONE_W-1:0] w_tone_last;
    logic                w_final;
    logic [2:0]          w_nxt_idx;
    logic                w_nxt_rest;
    logic                w_first_rest;
    logic                w_sel_ok;
    logic                w_rpt;
    logic                w_seg_end;

    assign w_cur        = f_rom(r_tune_q, r_idx_q);
    assign w_cur_rest   = (w_cur[6:4] == c_N_REST);
    assign w_note_last  = (c_CNT_W'(w_cur[3:0]) << c_UNIT_LOG2) - c_CNT_W'(1);
    assign w_tone_last  = f_tone_last(w_cur[6:4]);
    assign w_final      = (r_idx_q == f_last(r_tune_q));
    assign w_nxt_idx    = w_final ? 3'd0 : r_idx_q + 3'd1;
    assign w_nxt_rest   = (f_note(r_tune_q, w_nxt_idx) == c_N_REST);
    assign w_first_rest = (f_note(tune_sel, 3'd0) == c_N_REST);
    assign w_sel_ok     = (int'({30'd0, tune_sel}) < NUM_TUNES);

`ifdef TUNE_REPEAT_EN
    assign w_rpt = tune_repeat;
`else
    assign w_rpt = 1'b0;
`endif

    always_comb begin
        w_state_d   = r_state_q;
        w_tune_d    = r_tune_q;
        w_idx_d     = r_idx_q;
        w_cnt_d     = r_cnt_q;
        w_tone_d    = r_tone_q;
        w_piezo_d   = r_piezo_q;
        w_piezo_n_d = r_piezo_n_q;
        w_busy_d    = r_busy_q;
        w_done_d    = 1'b0;
        w_seg_end   = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                w_idx_d     = '0;
                w_cnt_d     = '0;
                w_tone_d    = '0;
                w_piezo_d   = 1'b0;
                w_piezo_n_d = 1'b0;
                w_busy_d    = 1'b0;
                if (go && !stop && w_sel_ok) begin
                    w_state_d   = ST_PLAY;
                    w_tune_d    = tune_sel;
                    w_piezo_n_d = !w_first_rest;
                    w_busy_d    = 1'b1;
                end
            end

            ST_PLAY: begin
                if (r_cnt_q == w_note_last) begin
                    if (GAP_CYCLES > 0) begin
                        w_state_d   = ST_GAP;
                        w_cnt_d     = '0;
                        w_tone_d    = '0;
                        w_piezo_d   = 1'b0;
                        w_piezo_n_d = 1'b0;
                    end else begin
                        w_seg_end = 1'b1;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_W'(1);
                    // Rest notes hold both drives low and never toggle
                    if (!w_cur_rest) begin
                        if (r_tone_q == w_tone_last) begin
                            w_tone_d    = '0;
                            w_piezo_d   = !r_piezo_q;
                            w_piezo_n_d = r_piezo_q;
                        end else begin
                            w_tone_d = r_tone_q + c_TONE_W'(1);
                        end
                    end
                end
            end

            ST_GAP: begin
                if (r_cnt_q == c_GAP_LAST) begin
                    w_seg_end = 1'b1;
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_W'(1);
                end
            end

            ST_FINISH: begin
                w_state_d = ST_IDLE;
                w_idx_d   = '0;
                w_busy_d  = 1'b0;
            end

            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        // End of a note (and its gap): advance, restart, or finish
        if (w_seg_end) begin
            w_cnt_d   = '0;
            w_tone_d  = '0;
            w_piezo_d = 1'b0;
            if (w_final && !w_rpt) begin
                w_state_d   = ST_FINISH;
                w_done_d    = 1'b1;
                w_busy_d    = 1'b0;
                w_piezo_n_d = 1'b0;
            end else begin
                w_state_d   = ST_PLAY;
                w_idx_d     = w_nxt_idx;
                w_piezo_n_d = !w_nxt_rest;
            end
        end

        // Abort overrides every transition above, and never pulses done
        if (stop && (r_state_q != ST_IDLE)) begin
            w_state_d   = ST_IDLE;
            w_idx_d     = '0;
            w_cnt_d     = '0;
            w_tone_d    = '0;
            w_piezo_d   = 1'b0;
            w_piezo_n_d = 1'b0;
            w_busy_d    = 1'b0;
            w_done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= ST_IDLE;
            r_tune_q    <= '0;
            r_idx_q     <= '0;
            r_cnt_q     <= '0;
            r_tone_q    <= '0;
            r_piezo_q   <= 1'b0;
            r_piezo_n_q <= 1'b0;
            r_busy_q    <= 1'b0;
            r_done_q    <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_tune_q    <= w_tune_d;
            r_idx_q     <= w_idx_d;
            r_cnt_q     <= w_cnt_d;
            r_tone_q    <= w_tone_d;
            r_piezo_q   <= w_piezo_d;
            r_piezo_n_q <= w_piezo_n_d;
            r_busy_q    <= w_busy_d;
            r_done_q    <= w_done_d;
        end
    end

    assign piezo    = r_piezo_q;
    assign piezo_n  = r_piezo_n_q;
    assign busy     = r_busy_q;
    assign done     = r_done_q;
    assign note_idx = r_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_tune_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_tune_player
// Description : Scoreboard bench for tune_player. Two instances share the
//               stimulus: A (4 tunes, no gap) and B (3 tunes, 100-cycle gap).
//               Each issued go expands the tune into the list of output
//               changes it must produce; per-instance monitors compare every
//               observed output change against that list.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tune_player;

    localparam int c_CLK_HZ = 100_000;
    localparam int c_UNIT   = 1024;
    localparam int c_NT_A   = 4;
    localparam int c_GAP_A  = 0;
    localparam int c_NT_B   = 3;
    localparam int c_GAP_B  = 100;

    typedef struct {
        int         t;
        logic [6:0] v;   // {busy, done, note_idx[2:0], piezo, piezo_n}
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       go;
    logic       stop;
    logic [1:0] tune_sel;
`ifdef TUNE_REPEAT_EN
    logic       tune_repeat = 1'b0;
`endif
    logic       pz_a, pzn_a, busy_a, done_a;
    logic [2:0] idx_a;
    logic       pz_b, pzn_b, busy_b, done_b;
    logic [2:0] idx_b;

    tune_player #(
        .CLK_FREQ_HZ(c_CLK_HZ), .FAST_SIM(1), .NUM_TUNES(c_NT_A), .GAP_CYCLES(c_GAP_A)
    ) u_dut_a (
        .clk(clk), .rst(rst), .go(go), .stop(stop), .tune_sel(tune_sel),
`ifdef TUNE_REPEAT_EN
        .tune_repeat(tune_repeat),
`endif
        .piezo(pz_a), .piezo_n(pzn_a), .busy(busy_a), .done(done_a), .note_idx(idx_a)
    );

    tune_player #(
        .CLK_FREQ_HZ(c_CLK_HZ), .FAST_SIM(1), .NUM_TUNES(c_NT_B), .GAP_CYCLES(c_GAP_B)
    ) u_dut_b (
        .clk(clk), .rst(rst), .go(go), .stop(stop), .tune_sel(tune_sel),
`ifdef TUNE_REPEAT_EN
        .tune_repeat(tune_repeat),
`endif
        .piezo(pz_b), .piezo_n(pzn_b), .busy(busy_b), .done(done_b), .note_idx(idx_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         total = 0;
    int         bad   = 0;
    ev_t        q_a[$];
    ev_t        q_b[$];
    int         idle_from [2];
    int         stop_k = 0;
    bit         mon_en = 1'b0;
    logic [6:0] prev_v [2];

    // ------------------------------------------------------------------
    // Reference model: tunes as (frequency in Hz, length in units)
    // ------------------------------------------------------------------
    function automatic int tune_len(input int tn);
        case (tn)
            0:       return 6;
            1:       return 5;
            2:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int note_hz(input int tn, input int n);
        case (tn)
            0: case (n) 0: return 1568; 1: return 2093; 2: return 2637;
                        3: return 3136; 4: return 2637; default: return 3136; endcase
            1: case (n) 0: return 2093; 1: return 0; 2: return 2093;
                        3: return 0; default: return 3136; endcase
            2: case (n) 0: return 2637; 1: return 1568; 2: return 2637;
                        default: return 1568; endcase
            default: return 3136;
        endcase
    endfunction

    function automatic int note_units(input int tn, input int n);
        case (tn)
            0: case (n) 0: return 2; 1: return 2; 2: return 2;
                        3: return 3; 4: return 1; default: return 4; endcase
            1: return (n == 4) ? 2 : 1;
            2: return 1;
            default: return 8;
        endcase
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? q_a.size() : q_b.size();
    endfunction

    function automatic int qfront_t(input int i);
        return (i == 0) ? q_a[0].t : q_b[0].t;
    endfunction

    task automatic qpush(input int i, input int t, input logic [6:0] v);
        ev_t e;
        e.t = t;
        e.v = v;
        if (i == 0) q_a.push_back(e);
        else        q_b.push_back(e);
    endtask

    task automatic qpop(input int i, output ev_t e);
        if (i == 0) e = q_a.pop_front();
        else        e = q_b.pop_front();
    endtask

    // Expand one tune, starting with busy visible at cycle s, into the list of
    // output changes; truncated to an idle state by a planned stop.
    task automatic build(input int inst, input int tn, input int s, input int gap);
        logic [6:0] prev;
        logic [6:0] v;
        logic       p, pn;
        int         t, hz, hp, dur;
        bit         ab;
        prev = 7'd0;
        t    = s;
        ab   = 1'b0;
        for (int n = 0; n < tune_len(tn) && !ab; n++) begin
            hz  = note_hz(tn, n);
            dur = note_units(tn, n) * c_UNIT;
            hp  = (hz > 0) ? c_CLK_HZ / (2 * hz) : 1;
            for (int o = 0; o < dur + gap && !ab; o++) begin
                if (stop_k > 0 && t >= stop_k) begin
                    ab = 1'b1;
                end else begin
                    p  = (hz > 0 && o < dur) ? ((o / hp) % 2 == 1) : 1'b0;
                    pn = (hz > 0 && o < dur) ? !p : 1'b0;
                    v  = {1'b1, 1'b0, 3'(n), p, pn};
                    if (v != prev) begin
                        qpush(inst, t, v);
                        prev = v;
                    end
                    t++;
                end
            end
        end
        if (!ab && !(stop_k > 0 && t >= stop_k)) begin
            v = {1'b0, 1'b1, 3'(tune_len(tn) - 1), 2'b00};
            qpush(inst, t, v);
            prev = v;
            t++;
        end
        if (prev != 7'd0) qpush(inst, t, 7'd0);
        idle_from[inst] = t;
    endtask

    // ------------------------------------------------------------------
    // Monitors
    // ------------------------------------------------------------------
    task automatic check_inst(input int i, input logic [6:0] cur);
        ev_t e;
        while (qsize(i) > 0 && qfront_t(i) < cyc) begin
            qpop(i, e);
            total++;
            bad++;
            $display("FAIL missed_change dut%0d: outputs %b at cycle %0d, required %b from cycle %0d",
                     i, cur, cyc, e.v, e.t);
        end
        if (cur !== prev_v[i]) begin
            total++;
            if (qsize(i) == 0) begin
                bad++;
                $display("FAIL unexpected_change dut%0d: outputs %b at cycle %0d, required %b (no change due)",
                         i, cur, cyc, prev_v[i]);
            end else begin
                qpop(i, e);
                if (e.t != cyc || e.v !== cur) begin
                    bad++;
                    $display("FAIL output_change dut%0d: got %b at cycle %0d, required %b at cycle %0d",
                             i, cur, cyc, e.v, e.t);
                end
            end
            prev_v[i] = cur;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check_inst(0, {busy_a, done_a, idx_a, pz_a, pzn_a});
            check_inst(1, {busy_b, done_b, idx_b, pz_b, pzn_b});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus (all tasks entered just after a falling edge)
    // ------------------------------------------------------------------
    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic issue_go(input logic [1:0] sel, input bit with_stop);
        if (!with_stop) begin
            if (cyc >= idle_from[0] && int'(sel) < c_NT_A) build(0, int'(sel), cyc + 1, c_GAP_A);
            if (cyc >= idle_from[1] && int'(sel) < c_NT_B) build(1, int'(sel), cyc + 1, c_GAP_B);
        end
        go       = 1'b1;
        tune_sel = sel;
        stop     = with_stop;
        @(negedge clk);
        go   = 1'b0;
        stop = 1'b0;
    endtask

    task automatic run(input logic [1:0] sel, input int stop_off, input int mid_off,
                       input logic [1:0] mid_sel);
        int s;
        s      = cyc + 1;
        stop_k = (stop_off > 0) ? s + stop_off : 0;
        issue_go(sel, 1'b0);
        if (mid_off > 0) begin
            wait_until(s + mid_off);
            issue_go(mid_sel, 1'b0);
        end
        if (stop_k > 0) begin
            wait_until(stop_k - 1);
            stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
        end
        wait_until(((idle_from[0] > idle_from[1]) ? idle_from[0] : idle_from[1]) + 5);
        stop_k = 0;
    endtask

    initial begin
        rst          = 1'b1;
        go           = 1'b1;
        stop         = 1'b0;
        tune_sel     = 2'd0;
        idle_from[0] = 0;
        idle_from[1] = 0;

        // Reset dominates a held go
        repeat (3) begin
            @(negedge clk);
            total++;
            if ({busy_a, done_a, idx_a, pz_a, pzn_a, busy_b, done_b, idx_b, pz_b, pzn_b} !== 14'd0) begin
                bad++;
                $display("FAIL reset_outputs: got a=%b b=%b, required all zero",
                         {busy_a, done_a, idx_a, pz_a, pzn_a}, {busy_b, done_b, idx_b, pz_b, pzn_b});
            end
        end
        rst       = 1'b0;
        go        = 1'b0;
        prev_v[0] = 7'd0;
        prev_v[1] = 7'd0;
        mon_en    = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: busy a=%b b=%b, required 0", busy_a, busy_b);
        end

        run(2'd0, 0, 0, 2'd0);                        // full tune 0
        run(2'd1, 0, 600, 2'($urandom_range(0, 3)));  // rests, go while busy
        run(2'd2, 0, 0, 2'd0);                        // gaps on B
        run(2'd3, 0, 0, 2'd0);                        // invalid on B
        run(2'd0, 3000, 0, 2'd0);                     // abort mid-note
        issue_go(2'd1, 1'b1);                         // go with stop in IDLE
        repeat (20) @(negedge clk);

        for (int r = 0; r < 3; r++) begin
            run(2'($urandom_range(0, 3)), int'($urandom_range(1500, 4000)),
                int'($urandom_range(10, 1000)), 2'($urandom_range(0, 3)));
        end

        repeat (10) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (qsize(i) != 0) begin
                bad++;
                $display("FAIL pending_changes dut%0d: %0d outstanding, required 0", i, qsize(i));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
